// File: rtl/cache_ctrl.sv
// Direct-mapped, one-word-line data cache controller with read-miss fill,
// write-through stores and a sequential whole-cache flush. Build option: CACHE_STATS_EN adds hit/miss counters.
module cache_ctrl #(
    parameter int SET_BITS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int LINES = 1 << SET_BITS;
    localparam int TAG_W = 32 - SET_BITS - 2;
    localparam logic [SET_BITS-1:0] IDX_ZERO = {SET_BITS{1'b0}};
    localparam logic [SET_BITS-1:0] IDX_ONE  = {{(SET_BITS-1){1'b0}}, 1'b1};
    localparam logic [SET_BITS-1:0] IDX_LAST = {SET_BITS{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [LINES-1:0]     valid_r;
    logic [TAG_W-1:0]     tag_r  [0:LINES-1];
    logic [31:0]          data_r [0:LINES-1];
    logic [SET_BITS-1:0]  flush_idx_r;

    logic [SET_BITS-1:0]  index_s;
    logic [TAG_W-1:0]     tag_s;
    logic                 hit_s;
    logic                 req_start_s;
    logic                 req_we_s;
    logic                 req_done_s;
    logic                 fill_s;
    logic                 store_hit_s;
    logic                 inval_s;
    logic [SET_BITS-1:0]  inval_idx_s;
    logic                 flush_go_s;
    logic                 unused_s;

    assign index_s  = cpu_addr[SET_BITS+1:2];
    assign tag_s    = cpu_addr[31:SET_BITS+2];
    assign hit_s    = valid_r[index_s] && (tag_r[index_s] == tag_s);
    assign unused_s = ^cpu_addr[1:0];

    // Next-state decode, stall and load-data return.
    always_comb begin
        state_nxt_s = state_r;
        cpu_stall   = 1'b0;
        cpu_rdata   = 32'd0;
        req_start_s = 1'b0;
        req_we_s    = 1'b0;
        req_done_s  = 1'b0;
        fill_s      = 1'b0;
        store_hit_s = 1'b0;
        inval_s     = 1'b0;
        inval_idx_s = IDX_ZERO;
        flush_go_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (flush) begin
                    // The request cycle already clears line 0, so the flush spans exactly LINES cycles.
                    flush_go_s  = 1'b1;
                    inval_s     = 1'b1;
                    inval_idx_s = IDX_ZERO;
                    cpu_stall   = cpu_req;
                    state_nxt_s = FLUSH;
                end else if (cpu_req) begin
                    if (cpu_we) begin
                        cpu_stall   = 1'b1;
                        req_start_s = 1'b1;
                        req_we_s    = 1'b1;
                        store_hit_s = hit_s;
                        state_nxt_s = WRITE;
                    end else if (hit_s) begin
                        cpu_rdata   = data_r[index_s];
                    end else begin
                        cpu_stall   = 1'b1;
                        req_start_s = 1'b1;
                        state_nxt_s = FILL;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    cpu_rdata   = mem_rdata;
                    fill_s      = 1'b1;
                    req_done_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    cpu_stall   = 1'b1;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    req_done_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    cpu_stall   = 1'b1;
                end
            end
            FLUSH: begin
                cpu_stall   = cpu_req;
                inval_s     = 1'b1;
                inval_idx_s = flush_idx_r;
                if (flush_idx_r == IDX_LAST) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, valid bits and flush index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            valid_r     <= {LINES{1'b0}};
            flush_idx_r <= IDX_ZERO;
        end else begin
            state_r <= state_nxt_s;
            if (inval_s) begin
                valid_r[inval_idx_s] <= 1'b0;
            end else if (fill_s) begin
                valid_r[index_s] <= 1'b1;
            end else begin
                valid_r <= valid_r;
            end
            if (flush_go_s) begin
                flush_idx_r <= IDX_ONE;
            end else if (state_r == FLUSH) begin
                flush_idx_r <= flush_idx_r + IDX_ONE;
            end else begin
                flush_idx_r <= flush_idx_r;
            end
        end
    end

    // Memory-port request registers; reset abandons any outstanding transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else if (req_start_s) begin
            mem_req  <= 1'b1;
            mem_we   <= req_we_s;
            mem_addr <= {cpu_addr[31:2], 2'b00};
            if (req_we_s) begin
                mem_wdata <= cpu_wdata;
            end else begin
                mem_wdata <= mem_wdata;
            end
        end else if (req_done_s) begin
            mem_req <= 1'b0;
        end else begin
            mem_req <= mem_req;
        end
    end

    // Tag and data arrays; contents are qualified by valid_r so need no reset.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            tag_r[index_s]  <= tag_s;
            data_r[index_s] <= mem_rdata;
        end else if (store_hit_s) begin
            data_r[index_s] <= cpu_wdata;
        end else begin
            data_r[index_s] <= data_r[index_s];
        end
    end

`ifdef CACHE_STATS_EN
    logic        hit_evt_s;
    logic        miss_evt_s;
    logic [31:0] hit_cnt_r;
    logic [31:0] miss_cnt_r;

    // A fill-completed load is returned from FILL, so it never counts as a hit.
    assign hit_evt_s  = (state_r == IDLE) && !flush && cpu_req && !cpu_we && hit_s;
    assign miss_evt_s = (state_r == IDLE) && !flush && cpu_req && !cpu_we && !hit_s;

    // Load hit/miss statistics, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else begin
            if (hit_evt_s) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end else begin
                hit_cnt_r <= hit_cnt_r;
            end
            if (miss_evt_s) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end else begin
                miss_cnt_r <= miss_cnt_r;
            end
        end
    end

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;
`else
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
`endif

endmodule
